// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Purpose : Bundles the decode-stage inputs, hazard-unit controls and
//           execute-stage outputs of the ID/EX pipeline register.
// Modports:
//   master - decode stage / hazard unit side. It drives FlushE, StallE,
//            ClearCount and every *D field, and observes every *E field
//            plus ValidE and BubbleCount.
//   slave  - the pipeline register itself. It has the opposite directions.
// Parameters: DATA_WIDTH, REG_ADDR_WIDTH, COUNT_WIDTH (field widths)
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
);
    // Hazard / debug controls
    logic                      FlushE;
    logic                      StallE;
    logic                      ClearCount;

    // Decode-stage fields
    logic                      RegWriteD;
    logic                      MemtoRegD;
    logic                      MemWriteD;
    logic [2:0]                ALUControlD;
    logic                      ALUSrcD;
    logic                      RegDstD;
    logic [DATA_WIDTH-1:0]     RD1D;
    logic [DATA_WIDTH-1:0]     RD2D;
    logic [REG_ADDR_WIDTH-1:0] RsD;
    logic [REG_ADDR_WIDTH-1:0] RtD;
    logic [REG_ADDR_WIDTH-1:0] RdD;
    logic [DATA_WIDTH-1:0]     SignImmD;

    // Execute-stage fields
    logic                      RegWriteE;
    logic                      MemtoRegE;
    logic                      MemWriteE;
    logic [2:0]                ALUControlE;
    logic                      ALUSrcE;
    logic                      RegDstE;
    logic [DATA_WIDTH-1:0]     RD1E;
    logic [DATA_WIDTH-1:0]     RD2E;
    logic [REG_ADDR_WIDTH-1:0] RsE;
    logic [REG_ADDR_WIDTH-1:0] RtE;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [DATA_WIDTH-1:0]     SignImmE;
    logic [REG_ADDR_WIDTH-1:0] WriteRegE;
    logic                      ValidE;
    logic [COUNT_WIDTH-1:0]    BubbleCount;

    modport master (
        output FlushE, StallE, ClearCount,
        output RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD, RegDstD,
        output RD1D, RD2D, RsD, RtD, RdD, SignImmD,
        input  RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
        input  RD1E, RD2E, RsE, RtE, RdE, SignImmE, WriteRegE, ValidE, BubbleCount
    );

    modport slave (
        input  FlushE, StallE, ClearCount,
        input  RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD, RegDstD,
        input  RD1D, RD2D, RsD, RtD, RdD, SignImmD,
        output RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
        output RD1E, RD2E, RsE, RtE, RdE, SignImmE, WriteRegE, ValidE, BubbleCount
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Purpose : Decode-to-execute pipeline register of the 5-stage MIPS core.
//           It captures the decoded control bits, operands and register
//           specifiers, and inserts a bubble on FlushE. It holds its contents
//           on StallE. It also keeps a saturating count of inserted bubbles.
// Ports   :
//   clk   - clock; all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - id_ex_pipe_reg_if.slave carrying FlushE/StallE/ClearCount,
//           all *D inputs, all *E outputs, WriteRegE, ValidE, BubbleCount
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_pipe_reg_if.slave   bus
);

    // One E-stage slot. An all-zero value is both the reset state and a
    // bubble. A bubble therefore never writes state, and its zeroed
    // specifiers point at register 0, which never forwards.
    typedef struct packed {
        logic                      regWrite;
        logic                      memtoReg;
        logic                      memWrite;
        logic [2:0]                aluControl;
        logic                      aluSrc;
        logic                      regDst;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     signImm;
        logic                      valid;
    } eSlot_t;

    eSlot_t                 eSlot;
    eSlot_t                 dSlot;
    logic [COUNT_WIDTH-1:0] bubbleCount;

    // Decode-stage fields as they would look once captured.
    always_comb begin
        dSlot            = '0;
        dSlot.regWrite   = bus.RegWriteD;
        dSlot.memtoReg   = bus.MemtoRegD;
        dSlot.memWrite   = bus.MemWriteD;
        dSlot.aluControl = bus.ALUControlD;
        dSlot.aluSrc     = bus.ALUSrcD;
        dSlot.regDst     = bus.RegDstD;
        dSlot.rd1        = bus.RD1D;
        dSlot.rd2        = bus.RD2D;
        dSlot.rs         = bus.RsD;
        dSlot.rt         = bus.RtD;
        dSlot.rd         = bus.RdD;
        dSlot.signImm    = bus.SignImmD;
        dSlot.valid      = 1'b1;
    end

    // Flush beats stall. A stalled instruction hit by a flush is discarded.
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eSlot <= '0;
        end else if (bus.FlushE) begin
            eSlot <= '0;
        end else if (!bus.StallE) begin
            eSlot <= dSlot;
        end
    end

    // Bubble counter. A clear that coincides with a flush still counts that
    // flush. The increment stops at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubbleCount <= '0;
        end else if (bus.ClearCount) begin
            bubbleCount <= bus.FlushE ? COUNT_WIDTH'(1) : '0;
        end else if (bus.FlushE && (bubbleCount != '1)) begin
            bubbleCount <= bubbleCount + COUNT_WIDTH'(1);
        end
    end

    assign bus.RegWriteE   = eSlot.regWrite;
    assign bus.MemtoRegE   = eSlot.memtoReg;
    assign bus.MemWriteE   = eSlot.memWrite;
    assign bus.ALUControlE = eSlot.aluControl;
    assign bus.ALUSrcE     = eSlot.aluSrc;
    assign bus.RegDstE     = eSlot.regDst;
    assign bus.RD1E        = eSlot.rd1;
    assign bus.RD2E        = eSlot.rd2;
    assign bus.RsE         = eSlot.rs;
    assign bus.RtE         = eSlot.rt;
    assign bus.RdE         = eSlot.rd;
    assign bus.SignImmE    = eSlot.signImm;
    assign bus.ValidE      = eSlot.valid;
    assign bus.BubbleCount = bubbleCount;

    // The destination mux sits after the register so the hazard unit sees
    // the E-stage destination in the same cycle.
    assign bus.WriteRegE   = eSlot.regDst ? eSlot.rd : eSlot.rt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Purpose : Self-checking bench for id_ex_pipe_reg. It drives directed
//           vectors through the interface and keeps a record-level model of
//           the E slot and the bubble count. Every negedge it compares all
//           outputs against that model, and it also checks a few literal
//           values. COUNT_WIDTH is 4 so that saturation is reachable.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit            regWrite, memtoReg, memWrite, aluSrc, regDst, valid;
        int unsigned   aluControl, rs, rt, rd;
        longint unsigned rd1, rd2, signImm;
    } eView_t;

    eView_t      expE;
    int          expCount;
    bit          modelLive = 1'b0;

    function automatic eView_t bubble();
        eView_t b;
        b = '{default: 0};
        return b;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            expE      <= bubble();
            expCount  <= 0;
            modelLive <= 1'b1;
        end else begin
            if (bus.ClearCount)
                expCount <= bus.FlushE ? 1 : 0;
            else if (bus.FlushE)
                expCount <= (expCount + 1 > MAXC) ? MAXC : expCount + 1;

            if (bus.FlushE)
                expE <= bubble();
            else if (!bus.StallE)
                expE <= '{regWrite: bus.RegWriteD, memtoReg: bus.MemtoRegD,
                          memWrite: bus.MemWriteD, aluSrc: bus.ALUSrcD,
                          regDst: bus.RegDstD, valid: 1'b1,
                          aluControl: bus.ALUControlD, rs: bus.RsD,
                          rt: bus.RtD, rd: bus.RdD, rd1: bus.RD1D,
                          rd2: bus.RD2D, signImm: bus.SignImmD};
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (modelLive) begin
            check("RegWriteE",   bus.RegWriteE,   expE.regWrite);
            check("MemtoRegE",   bus.MemtoRegE,   expE.memtoReg);
            check("MemWriteE",   bus.MemWriteE,   expE.memWrite);
            check("ALUSrcE",     bus.ALUSrcE,     expE.aluSrc);
            check("RegDstE",     bus.RegDstE,     expE.regDst);
            check("ALUControlE", bus.ALUControlE, expE.aluControl);
            check("RD1E",        bus.RD1E,        expE.rd1);
            check("RD2E",        bus.RD2E,        expE.rd2);
            check("SignImmE",    bus.SignImmE,    expE.signImm);
            check("RsE",         bus.RsE,         expE.rs);
            check("RtE",         bus.RtE,         expE.rt);
            check("RdE",         bus.RdE,         expE.rd);
            check("WriteRegE",   bus.WriteRegE,   expE.regDst ? expE.rd : expE.rt);
            check("ValidE",      bus.ValidE,      expE.valid);
            check("BubbleCount", bus.BubbleCount, expCount);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic driveD(input bit rw, input bit m2r, input bit mw, input logic [2:0] alu,
                          input bit src, input bit dst, input logic [DW-1:0] r1,
                          input logic [DW-1:0] r2, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                          input logic [DW-1:0] imm);
        bus.RegWriteD   = rw;
        bus.MemtoRegD   = m2r;
        bus.MemWriteD   = mw;
        bus.ALUControlD = alu;
        bus.ALUSrcD     = src;
        bus.RegDstD     = dst;
        bus.RD1D        = r1;
        bus.RD2D        = r2;
        bus.RsD         = rs;
        bus.RtD         = rt;
        bus.RdD         = rd;
        bus.SignImmD    = imm;
    endtask

    initial begin
        // 1. Reset with every D input non-zero
        rst_n          = 1'b0;
        bus.FlushE     = 1'b0;
        bus.StallE     = 1'b0;
        bus.ClearCount = 1'b0;
        driveD(1, 1, 1, 3'd7, 1, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd31, 5'd30, 5'd29, 32'h8000_0001);
        tick();
        tick();
        check("reset_ValidE",      bus.ValidE,      0);
        check("reset_BubbleCount", bus.BubbleCount, 0);
        check("reset_WriteRegE",   bus.WriteRegE,   0);
        check("reset_RD2E",        bus.RD2E,        0);

        // 2. Capture, then destination select follows RegDst
        rst_n = 1'b1;
        driveD(1, 0, 0, 3'd2, 0, 1, 32'h1234, 32'h0, 5'd3, 5'd5, 5'd9, 32'h10);
        tick();
        check("cap_RegWriteE", bus.RegWriteE, 1);
        check("cap_WriteRegE", bus.WriteRegE, 9);
        check("cap_RD1E",      bus.RD1E,      32'h1234);
        check("cap_ValidE",    bus.ValidE,    1);
        bus.RegDstD = 1'b0;
        tick();
        check("cap_WriteRegE_rt", bus.WriteRegE, 5);

        // 3. Load-use flush
        driveD(1, 1, 0, 3'd2, 1, 0, 32'h40, 32'h0, 5'd4, 5'd8, 5'd0, 32'h4);
        tick();
        check("load_MemtoRegE", bus.MemtoRegE, 1);
        bus.FlushE = 1'b1;
        tick();
        check("flush_MemtoRegE",   bus.MemtoRegE,   0);
        check("flush_RegWriteE",   bus.RegWriteE,   0);
        check("flush_MemWriteE",   bus.MemWriteE,   0);
        check("flush_RtE",         bus.RtE,         0);
        check("flush_ValidE",      bus.ValidE,      0);
        check("flush_BubbleCount", bus.BubbleCount, 1);

        // 4. Stall holds, then flush beats stall
        bus.FlushE = 1'b0;
        driveD(0, 0, 1, 3'd6, 1, 0, 32'h11, 32'hAAAA, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFC);
        tick();
        bus.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RD2D = 32'h5000 + i;
            tick();
        end
        check("stall_RD2E",      bus.RD2E,      32'hAAAA);
        check("stall_MemWriteE", bus.MemWriteE, 1);
        bus.FlushE = 1'b1;
        tick();
        check("stallflush_ValidE",      bus.ValidE,      0);
        check("stallflush_MemWriteE",   bus.MemWriteE,   0);
        check("stallflush_BubbleCount", bus.BubbleCount, 2);

        // Short mixed pattern: capture, back-to-back flushes, clear, capture
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        driveD(1, 0, 0, 3'd1, 0, 1, 32'hCAFE_0000, 32'h0000_BABE, 5'd17, 5'd18, 5'd19, 32'h7FFF);
        tick();
        bus.FlushE = 1'b1;
        tick();
        tick();
        check("b2b_BubbleCount", bus.BubbleCount, 4);
        bus.FlushE     = 1'b0;
        bus.ClearCount = 1'b1;
        driveD(0, 0, 1, 3'd5, 1, 0, 32'h1, 32'h2, 5'd6, 5'd7, 5'd8, 32'h3);
        tick();
        bus.ClearCount = 1'b0;
        check("clear_BubbleCount", bus.BubbleCount, 0);
        check("clear_WriteRegE",   bus.WriteRegE,   7);

        // 5. Counter saturation and clear interplay
        bus.FlushE = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_BubbleCount", bus.BubbleCount, 15);
        bus.FlushE     = 1'b0;
        bus.ClearCount = 1'b1;
        tick();
        check("clr_BubbleCount", bus.BubbleCount, 0);
        bus.FlushE = 1'b1;
        tick();
        check("clrflush_BubbleCount", bus.BubbleCount, 1);
        bus.ClearCount = 1'b0;

        // 6. Mid-operation reset overrides flush and stall
        bus.FlushE = 1'b0;
        driveD(1, 1, 1, 3'd4, 1, 1, 32'h9999, 32'h8888, 5'd10, 5'd11, 5'd12, 32'h7777);
        tick();
        bus.FlushE = 1'b1;
        bus.StallE = 1'b1;
        rst_n      = 1'b0;
        tick();
        check("midrst_ValidE",      bus.ValidE,      0);
        check("midrst_BubbleCount", bus.BubbleCount, 0);
        check("midrst_RD1E",        bus.RD1E,        0);
        check("midrst_WriteRegE",   bus.WriteRegE,   0);
        rst_n      = 1'b1;
        bus.FlushE = 1'b0;
        bus.StallE = 1'b0;
        tick();
        check("postrst_ValidE",    bus.ValidE,    1);
        check("postrst_WriteRegE", bus.WriteRegE, 12);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Decode-to-execute pipeline register for the 5-stage MIPS core. Captures the decoded control bits, register operands and register specifiers from the D stage, and presents them to the E stage and the hazard unit. The hazard unit reads RsE, RtE, WriteRegE, MemtoRegE and RegWriteE from this block. This block in turn acts on FlushE from the hazard unit. It also holds an E-stage stall hook and a saturating bubble counter for performance debug.

Parameters:
DATA_WIDTH, 32, width of operand and immediate fields
REG_ADDR_WIDTH, 5, width of register specifiers
COUNT_WIDTH, 16, width of bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
FlushE  input  1  insert bubble (from hazard unit)
StallE  input  1  hold current E contents (reserved for multicycle units; tie 0 otherwise)
ClearCount  input  1  synchronous clear of BubbleCount
RegWriteD  input  1  decoded register write enable
MemtoRegD  input  1  decoded load select
MemWriteD  input  1  decoded store enable
ALUControlD  input  3  decoded ALU op
ALUSrcD  input  1  immediate select
RegDstD  input  1  1 = Rd destination, 0 = Rt destination
RD1D  input  DATA_WIDTH  register file port 1 data
RD2D  input  DATA_WIDTH  register file port 2 data
RsD  input  REG_ADDR_WIDTH  source specifier
RtD  input  REG_ADDR_WIDTH  target specifier
RdD  input  REG_ADDR_WIDTH  destination specifier
SignImmD  input  DATA_WIDTH  sign-extended immediate
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1 each  registered control
ALUControlE  output  3  registered ALU op
RD1E, RD2E, SignImmE  output  DATA_WIDTH  registered data
RsE, RtE, RdE  output  REG_ADDR_WIDTH  registered specifiers
WriteRegE  output  REG_ADDR_WIDTH  combinational: RegDstE ? RdE : RtE
ValidE  output  1  1 = E holds a real instruction, 0 = bubble
BubbleCount  output  COUNT_WIDTH  number of bubbles inserted since reset or clear

Behaviour:
- Reset (rst_n=0 at clk edge): every registered output goes to 0, including ValidE and BubbleCount. WriteRegE therefore reads 0. Reset overrides FlushE, StallE and ClearCount.
- Latency: one cycle. D-stage inputs sampled at edge N appear on E outputs after edge N.
- Per-edge priority, when not in reset:
  1. FlushE=1: load bubble. All control bits = 0, ALUControlE = 0, RD1E/RD2E/SignImmE = 0, RsE/RtE/RdE = 0, ValidE = 0. FlushE beats StallE.
  2. Else if StallE=1: hold all E registers unchanged.
  3. Else: capture all D inputs and set ValidE = 1.
- A bubble must never write state: RegWriteE=0 and MemWriteE=0 guaranteed. Zeroed specifiers give register 0, which the hazard unit treats as non-forwarding.
- Bubble counter, evaluated each edge:
  - ClearCount=1: count goes to 0. If FlushE=1 in the same cycle, count goes to 1.
  - Else if FlushE=1: count increments by 1 and saturates at all-ones (no wrap).
  - Otherwise: count holds.
- No internal FSM beyond the valid/bubble state. ValidE goes 1 to 0 only on flush or reset, and 0 to 1 only on capture.
- Back-to-back flushes: each cycle inserts a bubble and counts once.
- Flush while StallE=1: the bubble is inserted; the held instruction is discarded (the stall owner must not rely on it).

Test Plan:
1. Reset: drive all D inputs non-zero, rst_n=0 for 2 edges -> every E output 0, ValidE=0, BubbleCount=0, WriteRegE=0.
2. Capture: RegWriteD=1, RegDstD=1, RtD=5, RdD=9, RD1D=0x1234, FlushE=0 for 1 edge -> RegWriteE=1, WriteRegE=9, RD1E=0x1234, ValidE=1. Then RegDstD=0 for the next edge -> WriteRegE=5.
3. Load-use flush: MemtoRegD=1, RegWriteD=1, RtD=8 captured, then FlushE=1 for one edge -> MemtoRegE=0, RegWriteE=0, RtE=0, ValidE=0, BubbleCount=1.
4. Stall vs flush: StallE=1 for 3 edges with RD2D changing each cycle -> RD2E holds its value. Then StallE=1 with FlushE=1 -> bubble loaded, BubbleCount increments.
5. Counter saturation: COUNT_WIDTH=4, FlushE=1 for 20 edges -> BubbleCount stays at 15. ClearCount=1 with FlushE=0 -> 0. ClearCount=1 with FlushE=1 -> 1.
6. Mid-operation reset: hold FlushE=1 and StallE=1 while pulsing rst_n=0 for one edge -> all outputs 0. After release with FlushE=0, StallE=0, the next capture sets ValidE=1.
